// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the dual-lane writeback arbiter.
// A single request format serves both lanes, the hold register and the output register.
package wb_arb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // 'reg' is a keyword, so the destination field is called dest.
    typedef struct packed {
        logic                     valid;
        logic [4:0]               dest;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_hold_reg.sv
// One-entry write-request register with load/clear and asynchronous reset.
// Clear drops only the valid bit; destination and data keep their last values.
module wb_hold_reg
    import wb_arb_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     clear,
    input  wb_req_t                  d,
    output logic                     valid,
    output logic [4:0]               dest,
    output logic [WB_DATA_WIDTH-1:0] data
);

    wb_req_t entry_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_p1 <= '0;
        end else if (load) begin
            entry_p1 <= d;
        end else if (clear) begin
            entry_p1.valid <= 1'b0;
        end
    end

    assign valid = entry_p1.valid;
    assign dest  = entry_p1.dest;
    assign data  = entry_p1.data;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the two writeback lanes onto the single register-file write port.
// Conflicting pairs emit lane 0 first and park lane 1 for one stall cycle.
module writeback_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid0,
    input  logic [4:0]            reg0,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic                  valid1,
    input  logic [4:0]            reg1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ready,
    output logic                  regWrite_out,
    output logic [4:0]            write_reg_out,
    output logic [DATA_WIDTH-1:0] write_data_out,
    output logic                  pend_valid,
    output logic [4:0]            pend_reg,
    output logic [CNT_WIDTH-1:0]  merge_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    state_t  state, next_state;
    logic    eff0, eff1;
    wb_req_t lane0, lane1, hold_entry, out_d;
    logic    out_load, out_clear, hold_load, hold_clear;
    logic    merge_inc, stall_inc;

    logic                     hold_valid;
    logic [4:0]               hold_dest;
    logic [WB_DATA_WIDTH-1:0] hold_data;
    logic                     out_valid;
    logic [4:0]               out_dest;
    logic [WB_DATA_WIDTH-1:0] out_data;

    assign eff0 = valid0 && (reg0 != REG_ZERO);
    assign eff1 = valid1 && (reg1 != REG_ZERO);

    assign lane0      = '{valid: 1'b1, dest: reg0, data: data0};
    assign lane1      = '{valid: 1'b1, dest: reg1, data: data1};
    assign hold_entry = '{valid: 1'b1, dest: hold_dest, data: hold_data};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        out_load   = 1'b0;
        out_clear  = 1'b0;
        out_d      = '0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        merge_inc  = 1'b0;
        stall_inc  = 1'b0;
        case (state)
            IDLE: begin
                case ({eff0, eff1})
                    2'b00: out_clear = 1'b1;
                    2'b10: begin
                        out_load = 1'b1;
                        out_d    = lane0;
                    end
                    2'b01: begin
                        out_load = 1'b1;
                        out_d    = lane1;
                    end
                    default: begin
                        out_load = 1'b1;
                        if (reg0 == reg1) begin
                            // Younger write to the same register wins outright.
                            out_d     = lane1;
                            merge_inc = 1'b1;
                        end else begin
                            out_d      = lane0;
                            hold_load  = 1'b1;
                            next_state = PEND;
                        end
                    end
                endcase
            end
            PEND: begin
                // Lane inputs are ignored here; upstream holds them while ready is low.
                out_load   = 1'b1;
                out_d      = hold_entry;
                hold_clear = 1'b1;
                stall_inc  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    wb_hold_reg u_hold (
        .clock (clock),
        .reset (reset),
        .load  (hold_load),
        .clear (hold_clear),
        .d     (lane1),
        .valid (hold_valid),
        .dest  (hold_dest),
        .data  (hold_data)
    );

    wb_hold_reg u_out (
        .clock (clock),
        .reset (reset),
        .load  (out_load),
        .clear (out_clear),
        .d     (out_d),
        .valid (out_valid),
        .dest  (out_dest),
        .data  (out_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            merge_count <= '0;
            stall_count <= '0;
        end else begin
            if (merge_inc) merge_count <= merge_count + CNT_WIDTH'(1);
            if (stall_inc) stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

    assign ready          = (state == IDLE);
    assign regWrite_out   = out_valid;
    assign write_reg_out  = out_dest;
    assign write_data_out = out_data;
    assign pend_valid     = hold_valid;
    assign pend_reg       = hold_dest;

endmodule
